// File: rtl/seg7_display.sv
`default_nettype none
// ============================================================================
// Module      : seg7_display
// Description : Bus-mapped driver for an 8-digit common-anode 7-segment
//               display. Holds a 32-bit DATA word (one hex nibble per digit)
//               and a CTRL word, and time-multiplexes the digits with a
//               programmable dwell of SCAN_DIV clocks per digit.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_result,
  output logic [7:0]  digit_sel,
  output logic [7:0]  segments
);

  // A one-cycle dwell still needs a 1-bit counter that simply stays at zero.
  localparam int          PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [16:0] CTRL_RST   = 17'h100FF;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  logic [31:0]   data_q;
  logic [16:0]   ctrl_q;       // only the implemented CTRL bits are stored
  logic [PW-1:0] presc_q;
  logic [2:0]    scan_idx_q;
  logic [7:0]    digit_sel_q;
  logic [7:0]    segments_q;

  logic [7:0]    digit_sel_d;
  logic [7:0]    segments_d;
  logic [3:0]    nibble;
  logic [6:0]    hex_seg;
  logic          lit;

  // Address bits above the word index and the unimplemented CTRL bits are
  // intentionally ignored; fold them into one sink signal.
  logic unused_bits;
  assign unused_bits = ^{addr[31:4], addr[1:0], write_data[31:17]};

  // Register file: DATA and CTRL accept full-word writes; STATUS and the
  // reserved slot silently drop writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 32'h0;
      ctrl_q <= CTRL_RST;
    end else if (write_enable) begin
      if (addr[3:2] == ADDR_DATA) data_q <= write_data;
      if (addr[3:2] == ADDR_CTRL) ctrl_q <= write_data[16:0];
    end
  end

  // Scan timebase: dwell SCAN_DIV clocks on each digit, then move on (7 -> 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      scan_idx_q <= 3'd0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q    <= '0;
      scan_idx_q <= scan_idx_q + 3'd1;
    end else begin
      presc_q    <= presc_q + 1'b1;
    end
  end

  // Select the current digit's nibble, decode it, and apply blanking/dp.
  always_comb begin
    nibble      = data_q[{scan_idx_q, 2'b00} +: 4];
    hex_seg     = 7'h7F;
    lit         = ctrl_q[16] & ctrl_q[scan_idx_q];
    digit_sel_d = 8'hFF;
    segments_d  = 8'hFF;
    case (nibble)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
    if (lit) begin
      digit_sel_d = ~(8'h01 << scan_idx_q);
      segments_d  = {~ctrl_q[8 + {2'b00, scan_idx_q}], hex_seg};
    end
  end

  // Pin registers: glitch-free outputs, one cycle behind the register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel_q <= 8'hFF;
      segments_q  <= 8'hFF;
    end else begin
      digit_sel_q <= digit_sel_d;
      segments_q  <= segments_d;
    end
  end

  // Combinational read mux on the word index.
  always_comb begin
    read_result = 32'h0;
    case (addr[3:2])
      ADDR_DATA:   read_result = data_q;
      ADDR_CTRL:   read_result = {15'h0, ctrl_q};
      ADDR_STATUS: read_result = {29'h0, scan_idx_q};
      default:     read_result = 32'h0;
    endcase
  end

  assign digit_sel = digit_sel_q;
  assign segments  = segments_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_display
// Description : Directed self-checking bench for seg7_display (SCAN_DIV = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_display;

  localparam int SCAN_DIV = 4;

  logic        clk;
  logic        rst_n;
  logic [31:0] addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_result;
  logic [7:0]  digit_sel;
  logic [7:0]  segments;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int lit_cnt [8];

  // Expected segments for DATA = 0x76543210, dp off, digits 0..7.
  logic [7:0] seg_tab [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

  seg7_display #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr         (addr),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_result  (read_result),
    .digit_sel    (digit_sel),
    .segments     (segments)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic int status_idx();
    return (cyc / SCAN_DIV) % 8;
  endfunction

  function automatic int pin_idx();
    return ((cyc - 1) / SCAN_DIV) % 8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a; write_data = d; write_enable = 1'b1;
    @(negedge clk);
    write_enable = 1'b0; addr = 32'h8;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = read_result;
  endtask

  task automatic check_digit(input string tag, input int idx,
                             input logic [7:0] sel, input logic [7:0] seg);
    bit found = 1'b0;
    for (int n = 0; n < 16 * SCAN_DIV + 4 && !found; n++) begin
      @(negedge clk);
      if (cyc >= 1 && pin_idx() == idx) found = 1'b1;
    end
    chk({tag, "_reached"}, {31'h0, found}, 32'h1);
    chk({tag, "_sel"}, {24'h0, digit_sel}, {24'h0, sel});
    chk({tag, "_seg"}, {24'h0, segments}, {24'h0, seg});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [7:0]  e_sel;
    int          oi;

    rst_n = 1'b0; write_enable = 1'b0; addr = 32'h0; write_data = 32'h0;

    // Power-on reset values
    repeat (2) @(negedge clk);
    chk("rst_sel", {24'h0, digit_sel}, 32'hFF);
    chk("rst_seg", {24'h0, segments}, 32'hFF);
    bus_read(32'h4, rd); chk("rst_ctrl", rd, 32'h000100FF);
    bus_read(32'h0, rd); chk("rst_data", rd, 32'h0);
    bus_read(32'h8, rd); chk("rst_status", rd, 32'h0);
    rst_n = 1'b1;

    // Scan with DATA = 0x76543210, one full rotation, dwell counted per digit
    bus_write(32'h0, 32'h76543210);
    for (int i = 0; i < 8; i++) lit_cnt[i] = 0;
    for (int n = 0; n < 8 * SCAN_DIV; n++) begin
      @(negedge clk);
      oi    = pin_idx();
      e_sel = ~(8'h01 << oi);
      chk("scan_sel", {24'h0, digit_sel}, {24'h0, e_sel});
      chk("scan_seg", {24'h0, segments}, {24'h0, seg_tab[oi]});
      chk("scan_status", read_result, status_idx());
      for (int i = 0; i < 8; i++) if (digit_sel[i] == 1'b0) lit_cnt[i]++;
    end
    for (int i = 0; i < 8; i++) chk("dwell", lit_cnt[i], SCAN_DIV);
    check_digit("d0", 0, 8'hFE, 8'hC0);
    check_digit("d5", 5, 8'hDF, 8'h92);

    // Enable and dp masks
    bus_write(32'h4, 32'h000181F0);
    @(negedge clk);
    bus_read(32'h4, rd); chk("mask_ctrl", rd, 32'h000181F0);
    addr = 32'h8;
    check_digit("m0", 0, 8'hFF, 8'hFF);
    check_digit("m3", 3, 8'hFF, 8'hFF);
    check_digit("m4", 4, 8'hEF, 8'h99);
    check_digit("m7", 7, 8'h7F, 8'h78);

    // Global off; upper CTRL bits are not stored
    bus_write(32'h4, 32'hFFFE00FF);
    @(negedge clk);
    bus_read(32'h4, rd); chk("off_ctrl", rd, 32'h000000FF);
    addr = 32'h8;
    for (int n = 0; n < 2 * SCAN_DIV * 2; n++) begin
      @(negedge clk);
      chk("off_sel", {24'h0, digit_sel}, 32'hFF);
      chk("off_seg", {24'h0, segments}, 32'hFF);
      chk("off_status", read_result, status_idx());
    end

    // Bus: writes to STATUS and reserved slot are dropped
    bus_write(32'h4, 32'h000100FF);
    bus_write(32'h8, 32'hDEADBEEF);
    bus_write(32'hC, 32'hDEADBEEF);
    bus_read(32'h0, rd); chk("bus_data", rd, 32'h76543210);
    bus_read(32'h4, rd); chk("bus_ctrl", rd, 32'h000100FF);
    bus_read(32'hC, rd); chk("bus_rsvd", rd, 32'h0);
    bus_read(32'h8, rd); chk("bus_status", rd, status_idx());

    // Write-to-pin latency: old value one cycle, new value the next
    bus_write(32'h0, 32'hFFFFFFFF);
    chk("lat_old", {24'h0, segments}, {24'h0, seg_tab[pin_idx()]});
    @(negedge clk);
    chk("lat_new", {24'h0, segments}, 32'h8E);

    // Asynchronous reset mid-scan, then restart from digit 0
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_sel", {24'h0, digit_sel}, 32'hFF);
    chk("arst_seg", {24'h0, segments}, 32'hFF);
    bus_read(32'h4, rd); chk("arst_ctrl", rd, 32'h000100FF);
    bus_read(32'h0, rd); chk("arst_data", rd, 32'h0);
    bus_read(32'h8, rd); chk("arst_status", rd, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_sel", {24'h0, digit_sel}, 32'hFE);
    chk("restart_seg", {24'h0, segments}, 32'hC0);
    chk("restart_st0", read_result, 32'h0);
    repeat (2) @(negedge clk);
    chk("restart_st3", read_result, 32'h0);
    @(negedge clk);
    chk("restart_st4", read_result, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
